// File: rtl/alu_unit_if.sv
// Issue/broadcast bundle between the reservation station, the ALU and the CDB.
// master = RS/CDB side, slave = execution unit.
interface alu_unit_if #(
   parameter int ROB_WIDTH = 3
);
   logic                 in_valid;
   logic [2:0]           in_op_L1;
   logic                 in_op_L2;
   logic [31:0]          in_opr1;
   logic [31:0]          in_opr2;
   logic [ROB_WIDTH:0]   in_rob_id;
   logic                 in_ready;
   logic                 out_valid;
   logic [31:0]          out_result;
   logic [ROB_WIDTH:0]   out_rob_id;
   logic                 out_grant;

   modport master (
      output in_valid, in_op_L1, in_op_L2,
      output in_opr1, in_opr2, in_rob_id,
      output out_grant,
      input  in_ready, out_valid,
      input  out_result, out_rob_id
   );

   modport slave (
      input  in_valid, in_op_L1, in_op_L2,
      input  in_opr1, in_opr2, in_rob_id,
      input  out_grant,
      output in_ready, out_valid,
      output out_result, out_rob_id
   );
endinterface

// File: rtl/alu_unit.sv
// RV32I integer ALU with a 2-entry result FIFO draining onto the CDB.
// Results leave in accept order; flush and reset empty the queue.
module alu_unit #(
   parameter int ROB_WIDTH = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   alu_unit_if.slave    bus
);
   logic [1:0]          count;
   logic                head;
   logic                tail;
   logic [31:0]         res_q [2];
   logic [ROB_WIDTH:0]  tag_q [2];
   logic [31:0]         alu_res;
   logic [4:0]          shamt;
   logic                push;
   logic                pop;

   assign shamt = bus.in_opr2[4:0];

   always_comb begin
      alu_res = '0;
      unique case (bus.in_op_L1)
         3'b000: alu_res = bus.in_op_L2 ?
                           bus.in_opr1 - bus.in_opr2 :
                           bus.in_opr1 + bus.in_opr2;
         3'b001: alu_res = bus.in_opr1 << shamt;
         3'b010: alu_res = {31'd0,
                     $signed(bus.in_opr1) < $signed(bus.in_opr2)};
         3'b011: alu_res = {31'd0, bus.in_opr1 < bus.in_opr2};
         3'b100: alu_res = bus.in_opr1 ^ bus.in_opr2;
         3'b101: alu_res = bus.in_op_L2 ?
                           32'($signed(bus.in_opr1) >>> shamt) :
                           bus.in_opr1 >> shamt;
         3'b110: alu_res = bus.in_opr1 | bus.in_opr2;
         3'b111: alu_res = bus.in_opr1 & bus.in_opr2;
         default: alu_res = '0;
      endcase
   end

   // Full FIFO still accepts when the head leaves this same cycle
   assign bus.in_ready  = rst_n &&
                          ((count != 2'd2) || bus.out_grant);
   assign bus.out_valid = (count != 2'd0);
   assign bus.out_result = bus.out_valid ? res_q[head] : '0;
   assign bus.out_rob_id = bus.out_valid ? tag_q[head] : '0;

   assign push = bus.in_valid && bus.in_ready && !flush;
   assign pop  = bus.out_grant && bus.out_valid && !flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            res_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else if (flush) begin
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else begin
         if (push) begin
            res_q[tail] <= alu_res;
            tag_q[tail] <= bus.in_rob_id;
            tail        <= tail + 1'b1;
         end
         if (pop)
            head <= head + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_unit.sv
// Vector table plus scoreboard bench for alu_unit.
// A negedge monitor models the FIFO and checks every visible output.
module tb_alu_unit;
   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   logic mon_on = 1'b0;
   logic [31:0] cur_exp;
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
   } exp_t;

   typedef struct {
      logic [2:0]  l1;
      logic        l2;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] exp;
   } vec_t;

   exp_t q[$];
   vec_t vecs[13];

   alu_unit_if #(.ROB_WIDTH(3)) bus ();

   alu_unit #(.ROB_WIDTH(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic ev;
      logic mready;
      if (mon_on) begin
         ev = (q.size() != 0);
         mready = rst_n && ((q.size() != 2) || bus.out_grant);
         check("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
         check("out_result", bus.out_result,
               ev ? q[0].res : 32'd0);
         check("out_rob_id", {28'd0, bus.out_rob_id},
               {28'd0, ev ? q[0].tag : 4'd0});
         check("in_ready", {31'd0, bus.in_ready}, {31'd0, mready});
         if (!rst_n || flush) begin
            q.delete();
         end else begin
            if (bus.out_grant && ev)
               void'(q.pop_front());
            if (bus.in_valid && mready)
               q.push_back('{cur_exp, bus.in_rob_id});
         end
      end
   end

   task automatic drive(input logic v, input logic [2:0] l1,
                        input logic l2, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag,
                        input logic [31:0] exp, input logic g);
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.in_op_L1  = l1;
      bus.in_op_L2  = l2;
      bus.in_opr1   = a;
      bus.in_opr2   = b;
      bus.in_rob_id = tag;
      bus.out_grant = g;
      cur_exp       = exp;
   endtask

   task automatic add(input logic [3:0] tag, input logic g);
      drive(1'b1, 3'b000, 1'b0, 32'd100, {28'd0, tag}, tag,
            32'd100 + {28'd0, tag}, g);
   endtask

   task automatic idle(input logic g);
      drive(1'b0, 3'b000, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0, g);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         idle(1'b1);
         n++;
      end
      check("drain_timeout", {31'd0, q.size() != 0}, 32'd0);
      idle(1'b0);
      idle(1'b0);
   endtask

   initial begin
      vecs[0]  = '{3'b000, 1'b0, 32'd5, 32'd7, 4'd3, 32'd12};
      vecs[1]  = '{3'b000, 1'b1, 32'd3, 32'd5, 4'd4, 32'hFFFFFFFE};
      vecs[2]  = '{3'b101, 1'b1, 32'h80000000, 32'd4, 4'd5,
                   32'hF8000000};
      vecs[3]  = '{3'b101, 1'b0, 32'h80000000, 32'd4, 4'd6,
                   32'h08000000};
      vecs[4]  = '{3'b001, 1'b0, 32'd1, 32'd35, 4'd7, 32'h8};
      vecs[5]  = '{3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd8, 32'd1};
      vecs[6]  = '{3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd9, 32'd0};
      vecs[7]  = '{3'b100, 1'b0, 32'hF0F0, 32'h0FF0, 4'd10, 32'hFF00};
      vecs[8]  = '{3'b110, 1'b0, 32'hF0F0, 32'h0FF0, 4'd11, 32'hFFF0};
      vecs[9]  = '{3'b111, 1'b0, 32'hF0F0, 32'h0FF0, 4'd12, 32'h00F0};
      vecs[10] = '{3'b000, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd13, 32'd0};
      vecs[11] = '{3'b001, 1'b1, 32'd1, 32'd4, 4'd14, 32'd16};
      vecs[12] = '{3'b110, 1'b1, 32'h1, 32'h2, 4'd15, 32'h3};

      rst_n = 1'b0;
      flush = 1'b0;
      idle(1'b0);
      mon_on = 1'b1;
      idle(1'b0);
      @(negedge clk);
      check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      rst_n = 1'b1;
      idle(1'b0);

      // ADD with grant low so the result sits visible, then drains
      drive(1'b1, 3'b000, 1'b0, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0);
      idle(1'b0);
      @(negedge clk);
      check("add_result", bus.out_result, 32'd12);
      check("add_tag", {28'd0, bus.out_rob_id}, 32'd3);
      drain();

      foreach (vecs[i])
         drive(1'b1, vecs[i].l1, vecs[i].l2, vecs[i].a, vecs[i].b,
               vecs[i].tag, vecs[i].exp, 1'b1);
      drain();

      // Back-pressure: tag 3 stalls until the CDB grants
      add(4'd1, 1'b0);
      add(4'd2, 1'b0);
      add(4'd3, 1'b0);
      @(negedge clk);
      check("stall_ready", {31'd0, bus.in_ready}, 32'd0);
      add(4'd3, 1'b1);
      drain();

      // Full FIFO, same-cycle pop and push
      add(4'd1, 1'b0);
      add(4'd2, 1'b0);
      add(4'd5, 1'b1);
      idle(1'b0);
      @(negedge clk);
      check("full_head", {28'd0, bus.out_rob_id}, 32'd2);
      check("full_count", {31'd0, bus.in_ready}, 32'd0);
      drain();

      // Flush with a simultaneous issue
      add(4'd1, 1'b0);
      add(4'd2, 1'b0);
      add(4'd7, 1'b1);
      flush = 1'b1;
      idle(1'b0);
      flush = 1'b0;
      @(negedge clk);
      check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
      check("flush_result", bus.out_result, 32'd0);
      idle(1'b1);
      idle(1'b1);

      // Same via reset
      add(4'd1, 1'b0);
      add(4'd2, 1'b0);
      add(4'd7, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
      idle(1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_tag", {28'd0, bus.out_rob_id}, 32'd0);
      idle(1'b1);
      idle(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
